// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage program-counter unit.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skidbuf.sv
// One-entry buffer holding a fetched instruction and its pc+4 while IF/ID is stalled.
module if_skidbuf
  import if_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_full,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        full_q, full_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  // A flush wins over any load or drain in the same cycle.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (i_clear) begin
      full_d = 1'b0;
    end else if (i_load) begin
      full_d  = 1'b1;
      instr_d = i_instr;
      pc4_d   = i_pc4;
    end else if (i_drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
    instr_q <= instr_d;
    pc4_q   <= pc4_d;
  end

  assign o_full  = full_q;
  assign o_instr = instr_q;
  assign o_pc4   = pc4_q;

endmodule

// File: rtl/if_pcgen.sv
// IF-stage PC unit: fetch FSM, PC/redirect handling and IF/ID output register.
module if_pcgen
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_con_pcsrc,
  input  logic [31:0] i_addr_JBpc,
  input  logic        i_con_stall,
  output logic        o_imem_req,
  output logic [31:0] o_addr_imem,
  input  logic        i_imem_ready,
  input  logic [31:0] i_data_imem,
  output logic [31:0] o_data_instr,
  output logic [31:0] o_addr_pc4,
  output logic        o_con_valid,
  output logic        o_con_flush,
  output logic        o_con_misalign
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;

  logic        fetch_done;
  logic        req_outstanding;
  logic        deliver;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;

  logic        skid_load, skid_drain, skid_clear, skid_full;
  logic [31:0] skid_instr, skid_pc4;

  assign fetch_done      = (state_q == S_FETCH) && i_imem_ready;
  assign req_outstanding = (state_q == S_FETCH) && !i_imem_ready;
  // A response is wrong-path if a redirect arrives with it or one is already pending.
  assign deliver         = fetch_done && !i_con_pcsrc && !pend_vld_q;
  assign pc_inc          = pc_q + PC_INC;
  assign redirect_tgt    = word_align(i_addr_JBpc);

  assign skid_load  = deliver && i_con_stall;
  assign skid_drain = !i_con_pcsrc && !i_con_stall && skid_full;
  assign skid_clear = i_con_pcsrc;

  if_skidbuf u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (skid_load),
    .i_drain (skid_drain),
    .i_clear (skid_clear),
    .i_instr (i_data_imem),
    .i_pc4   (pc_inc),
    .o_full  (skid_full),
    .o_instr (skid_instr),
    .o_pc4   (skid_pc4)
  );

  always_comb begin
    state_d    = state_q;
    o_imem_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (deliver && i_con_stall) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_con_pcsrc || !i_con_stall) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    flush_d     = i_con_pcsrc;
    misalign_d  = i_con_pcsrc && (i_addr_JBpc[1:0] != 2'b00);

    // The fetch address must stay put while a request is outstanding, so a
    // redirect then is parked until the in-flight response returns.
    if (i_con_pcsrc) begin
      if (req_outstanding) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = redirect_tgt;
      end else begin
        pc_d       = redirect_tgt;
        pend_vld_d = 1'b0;
      end
    end else if (fetch_done) begin
      pend_vld_d = 1'b0;
      pc_d       = pend_vld_q ? pend_addr_q : pc_inc;
    end

    if (i_con_pcsrc) begin
      valid_d = 1'b0;
    end else if (!i_con_stall) begin
      if (skid_full) begin
        instr_d = skid_instr;
        pc4_d   = skid_pc4;
        valid_d = 1'b1;
      end else if (deliver) begin
        instr_d = i_data_imem;
        pc4_d   = pc_inc;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VEC;
      pend_vld_q <= 1'b0;
      instr_q    <= NOP;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
    pend_addr_q <= pend_addr_d;
  end

  assign o_addr_imem    = pc_q;
  assign o_data_instr   = instr_q;
  assign o_addr_pc4     = pc4_q;
  assign o_con_valid    = valid_q;
  assign o_con_flush    = flush_q;
  assign o_con_misalign = misalign_q;

endmodule

// File: tb/tb_if_pcgen.sv
// Bench for if_pcgen: directed scenarios plus randomized traffic against a queue-based model.
module tb_if_pcgen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] jbpc = 32'd0;
  logic        stall = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] rdata = 32'd0;

  logic        imem_req;
  logic [31:0] addr_imem;
  logic [31:0] data_instr;
  logic [31:0] addr_pc4;
  logic        con_valid;
  logic        con_flush;
  logic        con_misalign;

  int chk_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  bit          m_idle, m_fetch, m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic [63:0] m_skid[$];
  logic [31:0] m_instr, m_pc4;
  bit          m_valid, m_flush, m_mis;

  if_pcgen #(.RESET_VEC(32'h0000_0000)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_con_pcsrc    (pcsrc),
    .i_addr_JBpc    (jbpc),
    .i_con_stall    (stall),
    .o_imem_req     (imem_req),
    .o_addr_imem    (addr_imem),
    .i_imem_ready   (ready),
    .i_data_imem    (rdata),
    .o_data_instr   (data_instr),
    .o_addr_pc4     (addr_pc4),
    .o_con_valid    (con_valid),
    .o_con_flush    (con_flush),
    .o_con_misalign (con_misalign)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit p, input logic [31:0] t,
                            input bit s, input bit rd, input logic [31:0] d);
    logic [31:0] old_pc, tgt;
    logic [63:0] e;
    bit done, got;
    if (r) begin
      m_idle = 1; m_fetch = 0; m_hold = 0;
      m_pc = 32'h0; m_pend.delete(); m_skid.delete();
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_flush = 0; m_mis = 0;
      return;
    end
    old_pc = m_pc;
    tgt    = t & 32'hFFFF_FFFC;
    done   = m_fetch && rd;
    got    = done && !p && (m_pend.size() == 0);
    m_flush = p;
    m_mis   = p && (t[1:0] != 2'b00);
    if (p) begin
      if (m_fetch && !rd) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end else begin
        m_pc = tgt;
        m_pend.delete();
      end
    end else if (done) begin
      if (m_pend.size() != 0) m_pc = m_pend.pop_front();
      else m_pc = old_pc + 32'd4;
    end
    if (p) begin
      m_valid = 0;
      m_skid.delete();
    end else if (!s) begin
      if (m_skid.size() != 0) begin
        e = m_skid.pop_front();
        m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1;
      end else if (got) begin
        m_instr = d; m_pc4 = old_pc + 32'd4; m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end else if (got) begin
      m_skid.push_back({d, old_pc + 32'd4});
    end
    if (m_idle) begin
      m_idle = 0; m_fetch = 1;
    end else if (m_hold) begin
      if (p || !s) begin m_hold = 0; m_fetch = 1; end
    end else if (got && s) begin
      m_fetch = 0; m_hold = 1;
    end
  endtask

  task automatic compare_all();
    check_eq("req", 32'(imem_req), 32'(m_fetch));
    if (m_fetch) check_eq("addr", addr_imem, m_pc);
    check_eq("instr", data_instr, m_instr);
    check_eq("pc4", addr_pc4, m_pc4);
    check_eq("valid", 32'(con_valid), 32'(m_valid));
    check_eq("flush", 32'(con_flush), 32'(m_flush));
    check_eq("misalign", 32'(con_misalign), 32'(m_mis));
  endtask

  // One clock: drive inputs, step DUT and model on the edge, compare 1 time unit later.
  task automatic cyc(input bit r, input bit p, input logic [31:0] t,
                     input bit s, input bit rd, input logic [31:0] d);
    rst = r; pcsrc = p; jbpc = t; stall = s; ready = rd; rdata = d;
    @(posedge clk);
    model_step(r, p, t, s, rd, d);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] hold_instr, hold_pc4, word_a, tgt;
    bit r, p, s, rd;

    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_instr", data_instr, 32'd0);
    check_eq("rst_valid", 32'(con_valid), 32'd0);

    // Sequential fetch with ready tied high
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1, 32'hA000_0000 + i);
      check_eq("seq_addr", addr_imem, 32'(4 * i));
      check_eq("seq_valid", 32'(con_valid), (i >= 1) ? 32'd1 : 32'd0);
    end

    // Redirect with the 0x10 response arriving the same cycle
    cyc(0, 1, 32'h0000_0100, 0, 1, 32'hDEAD_0010);
    check_eq("redir_flush", 32'(con_flush), 32'd1);
    check_eq("redir_valid", 32'(con_valid), 32'd0);
    check_eq("redir_addr", addr_imem, 32'h0000_0100);
    cyc(0, 0, 0, 0, 1, 32'hB000_0100);
    check_eq("redir_pc4", addr_pc4, 32'h0000_0104);
    check_eq("redir_instr", data_instr, 32'hB000_0100);

    // Outstanding fetch, redirect parked until the response returns
    cyc(0, 0, 0, 0, 0, 0);
    check_eq("pend_addr0", addr_imem, 32'h0000_0104);
    cyc(0, 1, 32'h0000_0200, 0, 0, 0);
    check_eq("pend_addr1", addr_imem, 32'h0000_0104);
    cyc(0, 0, 0, 0, 0, 0);
    check_eq("pend_addr2", addr_imem, 32'h0000_0104);
    cyc(0, 0, 0, 0, 1, 32'hBAD0_0104);
    check_eq("pend_drop", 32'(con_valid), 32'd0);
    check_eq("pend_next", addr_imem, 32'h0000_0200);
    cyc(0, 0, 0, 0, 1, 32'hC000_0200);
    check_eq("pend_pc4", addr_pc4, 32'h0000_0204);

    // Stall: one word into the skid, outputs frozen, then drain
    hold_instr = data_instr;
    hold_pc4   = addr_pc4;
    word_a     = 32'h1234_5678;
    cyc(0, 0, 0, 1, 1, word_a);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_req", 32'(imem_req), 32'd0);
      check_eq("stall_instr", data_instr, hold_instr);
      check_eq("stall_pc4", addr_pc4, hold_pc4);
      cyc(0, 0, 0, 1, 1, 32'hFFFF_0000);
    end
    cyc(0, 0, 0, 0, 1, 32'hFFFF_0001);
    check_eq("drain_instr", data_instr, word_a);
    check_eq("drain_pc4", addr_pc4, 32'h0000_0208);
    check_eq("drain_addr", addr_imem, 32'h0000_0208);
    cyc(0, 0, 0, 0, 1, 32'h8765_4321);
    check_eq("after_drain", addr_pc4, 32'h0000_020C);

    // Misaligned redirect and PC wrap
    cyc(0, 1, 32'h0000_0123, 0, 0, 0);
    check_eq("mis_pulse", 32'(con_misalign), 32'd1);
    cyc(0, 0, 0, 0, 1, 32'h0);
    check_eq("mis_addr", addr_imem, 32'h0000_0120);
    check_eq("mis_clear", 32'(con_misalign), 32'd0);
    cyc(0, 1, 32'hFFFF_FFFC, 0, 1, 32'h0);
    check_eq("wrap_top", addr_imem, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1, 32'h5555_AAAA);
    check_eq("wrap_addr", addr_imem, 32'h0000_0000);
    check_eq("wrap_pc4", addr_pc4, 32'h0000_0000);

    // Reset during an outstanding fetch
    cyc(0, 1, 32'h0000_0040, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    check_eq("mid_addr", addr_imem, 32'h0000_0040);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("mid_rst_req", 32'(imem_req), 32'd0);
    cyc(0, 0, 0, 0, 1, 32'h7777_7777);
    check_eq("mid_refetch", addr_imem, 32'h0000_0000);
    check_eq("mid_novalid", 32'(con_valid), 32'd0);
    cyc(0, 0, 0, 0, 1, 32'h6666_6666);
    check_eq("mid_pc4", addr_pc4, 32'h0000_0004);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 249) == 0);
      p  = ($urandom_range(0, 11) == 0);
      s  = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 9) < 6);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      cyc(r, p, tgt, s, rd, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
